alu_pipe_param: RTL and testbench
=================================

ALU_PIPE_PARAM -- requirements
Module: alu_pipe_param

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width; legal range 4..64.
REQ-002 Parameter SHW, default $clog2(WIDTH)+1: shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operation offered on opcode/input1/input2/shiftValue.
REQ-006 in_ready  output  1  block accepts the offered operation this cycle.
REQ-007 opcode  input  4  operation select per REQ-014.
REQ-008 input1, input2  input  WIDTH  operands.
REQ-009 shiftValue  input  SHW  shift amount.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 result  output  WIDTH; carryFlag, zeroFlag, overFlowFlag, signFlag, errFlag  output  1 each.
REQ-013 stickyOvf  output  1 and clr_sticky  input  1: accumulated overflow status and its synchronous clear.

Function
REQ-014 Opcodes: 0 SGE, 1 NAND, 2 SLL, 3 SGT, 4 MIN, 5 AND, 6 NOR, 7 SRA, 8 XOR, 9 ADD, 10 MAX, 11 SUB; 12-15 illegal.
REQ-015 Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-016 Two register stages: S1 captures operands/opcode, S2 holds computed result/flags; result/flags come directly from S2 registers.
REQ-017 Latency: accepted op appears on out_valid exactly 2 cycles after acceptance edge when out_ready held high.
REQ-018 Throughput 1 op/cycle with out_ready high; S1 advances when S2 empty or S2 transferring out; in_ready = S1 empty or S1 advancing (combinational from out_ready allowed, no path from in_valid).
REQ-019 Backpressure: with out_ready low, S2 and S1 hold; result/flags stable while out_valid high and out_ready low; no op dropped or duplicated; in_ready low when both stages full.
REQ-020 SGE/SGT: signed compare, result = 1 (zero-extended) if true else 0.
REQ-021 MIN/MAX: unsigned compare; equal operands return input1.
REQ-022 ADD: result = (input1+input2) mod 2^WIDTH; carryFlag = bit WIDTH of full sum; overFlowFlag = operands same sign and result sign differs.
REQ-023 SUB: result = input1-input2 mod 2^WIDTH; carryFlag = borrow (1 iff input1 < input2 unsigned); overFlowFlag = operand signs differ and result sign differs from input1.
REQ-024 SLL: result = input1 << shiftValue; shiftValue >= WIDTH gives 0; carryFlag = last bit shifted out (0 if shiftValue = 0, 0 if shiftValue > WIDTH, input1[0] if = WIDTH).
REQ-025 SRA: arithmetic right shift; shiftValue >= WIDTH gives all bits = input1[WIDTH-1].
REQ-026 NAND/AND/NOR/XOR bitwise; carryFlag and overFlowFlag 0 for all ops except those stated.
REQ-027 zeroFlag = (result == 0) and signFlag = result[WIDTH-1] for every op.
REQ-028 Illegal opcode: result 0, errFlag 1, zeroFlag 1, other flags 0; errFlag 0 for legal ops; op still occupies one pipeline slot.
REQ-029 stickyOvf sets on the output-transfer cycle of any op with overFlowFlag 1; stays set until clr_sticky.
REQ-030 clr_sticky high clears stickyOvf next edge; simultaneous set and clear: set wins.

Reset
REQ-031 rst_n low asynchronously empties both stages: out_valid 0, in_ready 0 while asserted, stickyOvf 0, result and all flags 0.
REQ-032 Reset mid-operation discards all in-flight ops; first edge after release: in_ready 1, out_valid 0.

Verification
REQ-033 WIDTH=8, ADD 0x7F+0x01 -> 2 cycles later result 0x80, overFlowFlag 1, carryFlag 0, signFlag 1, stickyOvf 1 after transfer.
REQ-034 WIDTH=8, SUB 0x00-0x01 -> result 0xFF, carryFlag 1, overFlowFlag 0; SRA 0x80 by 9 -> 0xFF; SLL 0x81 by 8 -> 0x00, carryFlag 1.
REQ-035 Stream 10 back-to-back ADDs, out_ready toggled 1/0 random -> 10 outputs in order, no gaps with out_ready high, held values stable when stalled.
REQ-036 out_ready low, offer 3 ops -> 2 accepted, in_ready 0 on third until out_ready rises.
REQ-037 opcode 13 -> result 0, errFlag 1, zeroFlag 1; next legal op errFlag 0.
REQ-038 rst_n low with 2 ops in flight -> out_valid 0 immediately, no output after release; WIDTH=32 rerun of REQ-033 with 0x7FFFFFFF+1 matches.

Source files
------------

// File: rtl/alu_pipe_param_if.sv
// rtl/alu_pipe_param_if.sv - operation/result handshake bundle for alu_pipe_param
interface alu_pipe_param_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [SHW-1:0]   shiftValue;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carryFlag;
    logic             zeroFlag;
    logic             overFlowFlag;
    logic             signFlag;
    logic             errFlag;
    logic             stickyOvf;
    logic             clr_sticky;

    modport master (
        output in_valid, opcode, input1, input2, shiftValue, out_ready, clr_sticky,
        input  in_ready, out_valid, result, carryFlag, zeroFlag, overFlowFlag,
               signFlag, errFlag, stickyOvf
    );

    modport slave (
        input  in_valid, opcode, input1, input2, shiftValue, out_ready, clr_sticky,
        output in_ready, out_valid, result, carryFlag, zeroFlag, overFlowFlag,
               signFlag, errFlag, stickyOvf
    );
endinterface

// File: rtl/alu_pipe_param.sv
// rtl/alu_pipe_param.sv - two-stage pipelined ALU with valid/ready flow control and sticky overflow
module alu_pipe_param #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_pipe_param_if.slave bus
);
    localparam logic [3:0] OP_SGE  = 4'd0;
    localparam logic [3:0] OP_NAND = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SGT  = 4'd3;
    localparam logic [3:0] OP_MIN  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_ADD  = 4'd9;
    localparam logic [3:0] OP_MAX  = 4'd10;
    localparam logic [3:0] OP_SUB  = 4'd11;

    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [SHW-1:0]   s1_sh_q, s1_sh_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic             s2_cy_q, s2_cy_d, s2_z_q, s2_z_d, s2_ov_q, s2_ov_d;
    logic             s2_sg_q, s2_sg_d, s2_er_q, s2_er_d;
    logic             sticky_q, sticky_d;

    logic             s2_ready, s1_adv, accept, xfer_out;
    logic [WIDTH:0]   sum_w, diff_w, shl_w;
    logic [WIDTH-1:0] sra_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cy, alu_ov, alu_er;

    // S2 can take a new result when empty or when its current one leaves this cycle
    assign xfer_out = s2_valid_q & bus.out_ready;
    assign s2_ready = ~s2_valid_q | bus.out_ready;
    assign s1_adv   = s1_valid_q & s2_ready;
    assign bus.in_ready = rst_n & (~s1_valid_q | s2_ready);
    assign accept   = bus.in_valid & bus.in_ready;

    assign sum_w  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign diff_w = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    // Bit WIDTH of the widened shift is the last bit shifted out; it is 0 past WIDTH
    assign shl_w  = {1'b0, s1_a_q} << s1_sh_q;
    assign sra_w  = $signed(s1_a_q) >>> s1_sh_q;

    always_comb begin
        alu_res = '0;
        alu_cy  = 1'b0;
        alu_ov  = 1'b0;
        alu_er  = 1'b0;
        case (s1_op_q)
            OP_SGE:  alu_res = WIDTH'($signed(s1_a_q) >= $signed(s1_b_q));
            OP_NAND: alu_res = ~(s1_a_q & s1_b_q);
            OP_SLL: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_cy  = shl_w[WIDTH];
            end
            OP_SGT:  alu_res = WIDTH'($signed(s1_a_q) > $signed(s1_b_q));
            OP_MIN:  alu_res = (s1_a_q <= s1_b_q) ? s1_a_q : s1_b_q;
            OP_AND:  alu_res = s1_a_q & s1_b_q;
            OP_NOR:  alu_res = ~(s1_a_q | s1_b_q);
            OP_SRA:  alu_res = sra_w;
            OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_cy  = sum_w[WIDTH];
                alu_ov  = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &
                          (sum_w[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_MAX:  alu_res = (s1_a_q >= s1_b_q) ? s1_a_q : s1_b_q;
            OP_SUB: begin
                alu_res = diff_w[WIDTH-1:0];
                alu_cy  = diff_w[WIDTH];
                alu_ov  = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &
                          (diff_w[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            default: alu_er = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d = accept | (s1_valid_q & ~s2_ready);
        s1_op_d    = accept ? bus.opcode     : s1_op_q;
        s1_a_d     = accept ? bus.input1     : s1_a_q;
        s1_b_d     = accept ? bus.input2     : s1_b_q;
        s1_sh_d    = accept ? bus.shiftValue : s1_sh_q;

        s2_valid_d = s1_adv | (s2_valid_q & ~bus.out_ready);
        s2_res_d   = s1_adv ? alu_res               : s2_res_q;
        s2_cy_d    = s1_adv ? alu_cy                : s2_cy_q;
        s2_z_d     = s1_adv ? (alu_res == '0)       : s2_z_q;
        s2_ov_d    = s1_adv ? alu_ov                : s2_ov_q;
        s2_sg_d    = s1_adv ? alu_res[WIDTH-1]      : s2_sg_q;
        s2_er_d    = s1_adv ? alu_er                : s2_er_q;

        // A set in the same cycle as a clear takes priority
        sticky_d   = (xfer_out & s2_ov_q) | (sticky_q & ~bus.clr_sticky);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sh_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_cy_q    <= 1'b0;
            s2_z_q     <= 1'b0;
            s2_ov_q    <= 1'b0;
            s2_sg_q    <= 1'b0;
            s2_er_q    <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_sh_q    <= s1_sh_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_cy_q    <= s2_cy_d;
            s2_z_q     <= s2_z_d;
            s2_ov_q    <= s2_ov_d;
            s2_sg_q    <= s2_sg_d;
            s2_er_q    <= s2_er_d;
            sticky_q   <= sticky_d;
        end
    end

    assign bus.out_valid    = s2_valid_q;
    assign bus.result       = s2_res_q;
    assign bus.carryFlag    = s2_cy_q;
    assign bus.zeroFlag     = s2_z_q;
    assign bus.overFlowFlag = s2_ov_q;
    assign bus.signFlag     = s2_sg_q;
    assign bus.errFlag      = s2_er_q;
    assign bus.stickyOvf    = sticky_q;
endmodule

// File: tb/tb_alu_pipe_param.sv
// tb/tb_alu_pipe_param.sv - self-checking bench for alu_pipe_param at WIDTH 8 and 32
module tb_alu_pipe_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_param_if #(.WIDTH(8))  bus8();
    alu_pipe_param_if #(.WIDTH(32)) bus32();

    alu_pipe_param #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    alu_pipe_param #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    typedef struct {
        logic [7:0] res;
        logic       c, z, o, s, e;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic sticky_m = 1'b0;
    logic rand_mode = 1'b0;
    logic out_ready_man = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour for WIDTH=8 in plain integer arithmetic
    function automatic exp_t model(input int op, input int a, input int b, input int sh);
        exp_t x;
        int sa, sb, r;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        r = 0; x.c = 0; x.o = 0; x.e = 0; x.acc = 0;
        case (op)
            0:  r = (sa >= sb) ? 1 : 0;
            1:  r = (~(a & b)) & 255;
            2: begin
                r = (sh >= 8) ? 0 : (a << sh) & 255;
                x.c = (sh == 0 || sh > 8) ? 1'b0 : 1'((a >> (8 - sh)) & 1);
            end
            3:  r = (sa > sb) ? 1 : 0;
            4:  r = (a <= b) ? a : b;
            5:  r = a & b;
            6:  r = (~(a | b)) & 255;
            7:  r = (sa >>> ((sh > 7) ? 7 : sh)) & 255;
            8:  r = a ^ b;
            9: begin
                r = (a + b) & 255;
                x.c = (a + b) > 255;
                x.o = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            10: r = (a >= b) ? a : b;
            11: begin
                r = (a - b) & 255;
                x.c = a < b;
                x.o = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            default: x.e = 1;
        endcase
        x.res = 8'(r);
        x.z = (r == 0);
        x.s = (r > 127);
        return x;
    endfunction

    // Output/handshake checker against the scoreboard, every cycle
    always @(negedge clk) begin
        logic exp_v, nxt;
        exp_t m;
        if (!rst_n) begin
            q.delete();
            sticky_m = 1'b0;
            check("rst_out_valid", bus8.out_valid, 0);
            check("rst_in_ready", bus8.in_ready, 0);
            check("rst_result", bus8.result, 0);
            check("rst_flags", {bus8.carryFlag, bus8.zeroFlag, bus8.overFlowFlag,
                                bus8.signFlag, bus8.errFlag}, 0);
            check("rst_sticky", bus8.stickyOvf, 0);
        end else begin
            exp_v = (q.size() > 0) && (q[0].acc + 2 <= cyc);
            check("out_valid", bus8.out_valid, exp_v);
            check("in_ready", bus8.in_ready, (q.size() < 2) || bus8.out_ready);
            check("stickyOvf", bus8.stickyOvf, sticky_m);
            if (exp_v) begin
                check("result", bus8.result, q[0].res);
                check("flags", {bus8.carryFlag, bus8.zeroFlag, bus8.overFlowFlag,
                                bus8.signFlag, bus8.errFlag},
                      {q[0].c, q[0].z, q[0].o, q[0].s, q[0].e});
            end
            nxt = sticky_m & ~bus8.clr_sticky;
            if (bus8.out_valid && bus8.out_ready && q.size() > 0) begin
                if (q[0].o) nxt = 1'b1;
                void'(q.pop_front());
            end
            sticky_m = nxt;
            if (bus8.in_valid && bus8.in_ready) begin
                m = model(int'(bus8.opcode), int'(bus8.input1), int'(bus8.input2),
                          int'(bus8.shiftValue));
                m.acc = cyc;
                q.push_back(m);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            bus8.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : out_ready_man;
        end
    end

    task automatic issue(input int op, input int a, input int b, input int sh);
        int n = 0;
        bus8.opcode = 4'(op);
        bus8.input1 = 8'(a);
        bus8.input2 = 8'(b);
        bus8.shiftValue = 4'(sh);
        bus8.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus8.in_ready) break;
            n++;
            if (n > 200) begin
                check("issue_timeout", bus8.in_ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus8.out_valid) break;
            n++;
            if (n > 200) begin
                check("out_timeout", bus8.out_valid, 1);
                break;
            end
        end
    endtask

    task automatic expect8(input string name, input logic [7:0] res, input logic [4:0] fl);
        check({name, "_res"}, bus8.result, res);
        check({name, "_flags"}, {bus8.carryFlag, bus8.zeroFlag, bus8.overFlowFlag,
                                 bus8.signFlag, bus8.errFlag}, fl);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // {carry, zero, ovf, sign, err}
    task automatic directed(input string name, input int op, input int a, input int b,
                            input int sh, input logic [7:0] res, input logic [4:0] fl);
        issue(op, a, b, sh);
        wait_out();
        expect8(name, res, fl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bus8.in_valid = 0; bus8.opcode = 0; bus8.input1 = 0; bus8.input2 = 0;
        bus8.shiftValue = 0; bus8.clr_sticky = 0; bus8.out_ready = 0;
        bus32.in_valid = 0; bus32.opcode = 0; bus32.input1 = 0; bus32.input2 = 0;
        bus32.shiftValue = 0; bus32.clr_sticky = 0; bus32.out_ready = 1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", bus8.in_ready, 1);
        check("release_out_valid", bus8.out_valid, 0);
        @(posedge clk);
        #1;

        // ADD overflow with exact two-cycle latency
        issue(9, 8'h7F, 8'h01, 0);
        @(negedge clk);
        check("lat_s1_out_valid", bus8.out_valid, 0);
        @(negedge clk);
        check("lat_s2_out_valid", bus8.out_valid, 1);
        expect8("add_ovf", 8'h80, 5'b00110);
        @(negedge clk);
        check("sticky_set", bus8.stickyOvf, 1);
        @(posedge clk);
        #1 bus8.clr_sticky = 1'b1;
        @(posedge clk);
        #1 bus8.clr_sticky = 1'b0;
        @(negedge clk);
        check("sticky_clr", bus8.stickyOvf, 0);
        @(posedge clk);
        #1;

        directed("sub_borrow", 11, 8'h00, 8'h01, 0, 8'hFF, 5'b10010);
        directed("sra_9",       7, 8'h80, 8'h00, 9, 8'hFF, 5'b00010);
        directed("sll_8",       2, 8'h81, 8'h00, 8, 8'h00, 5'b11000);
        directed("illegal_13", 13, 8'h12, 8'h34, 0, 8'h00, 5'b01001);
        directed("add_after",   9, 8'h01, 8'h01, 0, 8'h02, 5'b00000);
        directed("sge_neg",     0, 8'h80, 8'h01, 0, 8'h00, 5'b01000);
        directed("min_eq",      4, 8'h05, 8'h05, 0, 8'h05, 5'b00000);
        directed("sll_3",       2, 8'h31, 8'h00, 3, 8'h88, 5'b10010);

        // Every opcode back-to-back, checked by the model
        issue(0, 8'h05, 8'hFB, 0);
        issue(1, 8'hF0, 8'h3C, 0);
        issue(2, 8'h81, 8'h00, 1);
        issue(3, 8'h7F, 8'h80, 0);
        issue(4, 8'h80, 8'h7F, 0);
        issue(5, 8'hA5, 8'h0F, 0);
        issue(6, 8'h00, 8'h00, 0);
        issue(7, 8'h40, 8'h00, 3);
        issue(8, 8'hAA, 8'hAA, 0);
        issue(10, 8'h80, 8'h7F, 0);
        issue(11, 8'h80, 8'h01, 0);
        issue(15, 8'h01, 8'h01, 0);
        issue(2, 8'h01, 8'h00, 12);
        issue(7, 8'h40, 8'h00, 15);
        drain();

        // Backpressure: two accepted, third refused until out_ready rises
        out_ready_man = 1'b0;
        issue(9, 8'h10, 8'h20, 0);
        issue(11, 8'h30, 8'h05, 0);
        bus8.opcode = 4'd8; bus8.input1 = 8'h0F; bus8.input2 = 8'hF0; bus8.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", bus8.in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready_man = 1'b1;
        @(negedge clk);
        check("unstall_in_ready", bus8.in_ready, 1);
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        drain();

        // Overflow transfer coinciding with clear
        bus8.clr_sticky = 1'b1;
        issue(11, 8'h80, 8'h01, 0);
        wait_out();
        @(posedge clk);
        #1 bus8.clr_sticky = 1'b0;
        @(negedge clk);
        check("sticky_set_wins", bus8.stickyOvf, 1);
        @(posedge clk);
        #1;

        // Ten ADDs with random out_ready
        rand_mode = 1'b1;
        for (int i = 0; i < 10; i++) issue(9, (i * 37) & 255, (i * 11 + 100) & 255, 0);
        rand_mode = 1'b0;
        out_ready_man = 1'b1;
        drain();

        // Reset with two ops in flight
        out_ready_man = 1'b0;
        issue(9, 8'h03, 8'h04, 0);
        issue(9, 8'h05, 8'h06, 0);
        #1 check("pre_rst_out_valid", bus8.out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", bus8.out_valid, 0);
        check("async_rst_in_ready", bus8.in_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready_man = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_out_valid", bus8.out_valid, 0);
        end
        @(posedge clk);
        #1;

        // WIDTH=32 overflow
        bus32.opcode = 4'd9; bus32.input1 = 32'h7FFF_FFFF; bus32.input2 = 32'h1;
        bus32.in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus32.in_ready) break;
            n++;
            if (n > 50) begin
                check("w32_issue_timeout", bus32.in_ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1 bus32.in_valid = 1'b0;
        @(negedge clk);
        check("w32_lat_s1", bus32.out_valid, 0);
        @(negedge clk);
        check("w32_out_valid", bus32.out_valid, 1);
        check("w32_result", bus32.result, 32'h8000_0000);
        check("w32_flags", {bus32.carryFlag, bus32.zeroFlag, bus32.overFlowFlag,
                            bus32.signFlag, bus32.errFlag}, 5'b00110);
        @(negedge clk);
        check("w32_sticky", bus32.stickyOvf, 1);
        check("w32_drained", bus32.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
